stopwatch_ctrl: RTL and testbench

//  Control FSM for the 0-59 s stopwatch. Debounces start/stop and lap/reset buttons.

---
 rtl/stopwatch_ctrl_if.sv | 23 ++
 rtl/stopwatch_ctrl.sv | 112 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch control FSM and its surroundings
// (buttons, 1 Hz divider, second counter, display holder).
interface stopwatch_ctrl_if;
    logic       btn_ss;
    logic       btn_lr;
    logic       tick;
    logic [2:0] cur_ts;
    logic [3:0] cur_ss;
    logic       cnt_en;
    logic       cnt_clr;
    logic       hold;
    logic [1:0] state;

    modport master (
        output btn_ss, btn_lr, tick, cur_ts, cur_ss,
        input  cnt_en, cnt_clr, hold, state
    );

    modport slave (
        input  btn_ss, btn_lr, tick, cur_ts, cur_ss,
        output cnt_en, cnt_clr, hold, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: button sync/debounce, tick gating, counter clear, display hold.
// Optional STOPWATCH_AUTOSTOP_EN stops the run at 59 s instead of wrapping.
module stopwatch_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DB_W            = 20
) (
    input logic             clk,
    input logic             reset,
    stopwatch_ctrl_if.slave sw
);
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StStop = 2'b10,
        StLap  = 2'b11
    } state_e;

    localparam logic [DB_W-1:0] DbLast = DB_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0: start/stop, bit 1: lap/reset.
    logic [1:0]      raw;
    logic [1:0]      sync1_q, sync2_q, db_q, db_dly_q, press_q;
    logic [DB_W-1:0] db_cnt_q [2];

    assign raw = {sw.btn_lr, sw.btn_ss};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            db_dly_q    <= '0;
            press_q     <= '0;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            db_dly_q <= db_q;
            press_q  <= db_q & ~db_dly_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DbLast) begin
                    db_q[i]     <= ~db_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    state_e state_q;
    logic   hold_q, clr_q;
    logic   ps, pl, running, autostop;

    assign ps      = press_q[0];
    assign pl      = press_q[1];
    assign running = (state_q == StRun) || (state_q == StLap);

`ifdef STOPWATCH_AUTOSTOP_EN
    assign autostop = running & sw.tick & (sw.cur_ts == 3'd5) & (sw.cur_ss == 4'd9);
`else
    logic unused_cur;
    assign unused_cur = ^{sw.cur_ts, sw.cur_ss};
    assign autostop   = 1'b0;
`endif

    assign sw.cnt_en  = sw.tick & running & ~autostop;
    assign sw.cnt_clr = clr_q;
    assign sw.hold    = hold_q;
    assign sw.state   = state_q;

    // Priority: autostop, then start/stop, then lap/reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            hold_q  <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            clr_q <= 1'b0;
            if (autostop) begin
                state_q <= StStop;
                hold_q  <= 1'b0;
            end else if (ps) begin
                state_q <= running ? StStop : StRun;
                hold_q  <= 1'b0;
            end else if (pl) begin
                unique case (state_q)
                    StIdle, StStop: begin
                        state_q <= StIdle;
                        hold_q  <= 1'b0;
                        clr_q   <= 1'b1;
                    end
                    StRun: begin
                        state_q <= StLap;
                        hold_q  <= 1'b1;
                    end
                    StLap: begin
                        state_q <= StRun;
                        hold_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= StIdle;
                        hold_q  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4: expectations are queued
// tagged with the clock edge they apply to, and a monitor compares on the falling edge.
module tb_stopwatch_ctrl;
    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;

    stopwatch_ctrl_if sw ();

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .DB_W           (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sw   (sw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        int         sig;
        logic [1:0] val;
        string      name;
    } exp_t;

    exp_t q[$];

    // sig: 0 state, 1 hold, 2 cnt_clr, 3 cnt_en
    task automatic push(input int at, input int sig, input logic [1:0] val, input string name);
        exp_t e;
        int   pos;
        e.at   = at;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        pos    = q.size();
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].at > at) begin
                pos = i;
                break;
            end
        end
        q.insert(pos, e);
    endtask

    function automatic logic [1:0] sample(input int sig);
        case (sig)
            0:       return sw.state;
            1:       return {1'b0, sw.hold};
            2:       return {1'b0, sw.cnt_clr};
            default: return {1'b0, sw.cnt_en};
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t       e;
        logic [1:0] act;
        while (q.size() > 0 && q[0].at <= cyc) begin
            e   = q.pop_front();
            act = sample(e.sig);
            checks++;
            if (e.at != cyc || act !== e.val) begin
                failures++;
                $display("FAIL %s cyc=%0d due=%0d got=%0d expected=%0d",
                         e.name, cyc, e.at, act, e.val);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // which: 0 start/stop, 1 lap/reset, 2 both
    task automatic transition(input int which, input logic [1:0] from, input logic [1:0] to,
                              input logic h, input logic clr, input string name);
        int c;
        c = cyc;
        push(c + 7, 0, from, {name, "_pre"});
        push(c + 8, 0, to, {name, "_state"});
        push(c + 8, 1, {1'b0, h}, {name, "_hold"});
        push(c + 8, 2, {1'b0, clr}, {name, "_clr"});
        push(c + 9, 2, 2'd0, {name, "_clr_end"});
        push(c + 20, 0, to, {name, "_held"});
        if (which != 1) sw.btn_ss = 1'b1;
        if (which != 0) sw.btn_lr = 1'b1;
        step(12);
        sw.btn_ss = 1'b0;
        sw.btn_lr = 1'b0;
        step(12);
    endtask

    initial begin
        int c;
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        sw.btn_ss = 1'b0;
        sw.btn_lr = 1'b0;
        sw.tick   = 1'b1;
        sw.cur_ts = 3'd0;
        sw.cur_ss = 4'd0;

        step(3);
        push(cyc, 0, 2'b00, "rst_state");
        push(cyc, 1, 2'd0, "rst_hold");
        push(cyc, 2, 2'd0, "rst_clr");
        push(cyc, 3, 2'd0, "rst_cnt_en");
        checks++;
        if (sw.state !== 2'b00) begin
            failures++;
            $display("FAIL rst_state_direct got=%0d", sw.state);
        end
        checks++;
        if (sw.hold !== 1'b0) begin
            failures++;
            $display("FAIL rst_hold_direct got=%0d", sw.hold);
        end
        checks++;
        if (sw.cnt_clr !== 1'b0) begin
            failures++;
            $display("FAIL rst_clr_direct got=%0d", sw.cnt_clr);
        end
        checks++;
        if (sw.cnt_en !== 1'b0) begin
            failures++;
            $display("FAIL rst_cnt_en_direct got=%0d", sw.cnt_en);
        end
        step(2);
        reset   = 1'b0;
        sw.tick = 1'b0;
        step(2);

        // Bounce shorter than the debounce window.
        c = cyc;
        push(c + 8, 0, 2'b00, "bounce_state_a");
        push(c + 9, 2, 2'd0, "bounce_clr");
        push(c + 14, 0, 2'b00, "bounce_state_b");
        sw.btn_ss = 1'b1;
        step(3);
        sw.btn_ss = 1'b0;
        step(1);
        sw.btn_ss = 1'b1;
        step(2);
        sw.btn_ss = 1'b0;
        step(12);

        transition(0, 2'b00, 2'b01, 1'b0, 1'b0, "start");
        checks++;
        if (sw.state !== 2'b01) begin
            failures++;
            $display("FAIL start_state_direct got=%0d", sw.state);
        end
        sw.tick = 1'b1;
        push(cyc, 3, 2'd1, "run_tick1");
        step(1);
        sw.tick = 1'b0;
        push(cyc, 3, 2'd0, "run_tick0");
        step(1);

        transition(1, 2'b01, 2'b11, 1'b1, 1'b0, "lap");
        checks++;
        if (sw.hold !== 1'b1) begin
            failures++;
            $display("FAIL lap_hold_direct got=%0d", sw.hold);
        end
        sw.tick = 1'b1;
        push(cyc, 3, 2'd1, "lap_tick1");
        step(1);
        sw.tick = 1'b0;
        step(1);
        transition(1, 2'b11, 2'b01, 1'b0, 1'b0, "unlap");

        transition(0, 2'b01, 2'b10, 1'b0, 1'b0, "stop");
        sw.tick = 1'b1;
        push(cyc, 3, 2'd0, "stop_tick1");
        #1;
        checks++;
        if (sw.cnt_en !== 1'b0) begin
            failures++;
            $display("FAIL stop_cnt_en_direct got=%0d", sw.cnt_en);
        end
        step(1);
        sw.tick = 1'b0;
        step(1);
        transition(1, 2'b10, 2'b00, 1'b0, 1'b1, "clear");

        transition(0, 2'b00, 2'b01, 1'b0, 1'b0, "restart");
        transition(2, 2'b01, 2'b10, 1'b0, 1'b0, "simul");

        transition(0, 2'b10, 2'b01, 1'b0, 1'b0, "resume");
        sw.cur_ts = 3'd5;
        sw.cur_ss = 4'd9;
        sw.tick   = 1'b1;
`ifdef STOPWATCH_AUTOSTOP_EN
        push(cyc, 3, 2'd0, "auto_cnt_en");
        push(cyc + 1, 0, 2'b10, "auto_state");
`else
        push(cyc, 3, 2'd1, "auto_cnt_en");
        push(cyc + 1, 0, 2'b01, "auto_state");
`endif
        push(cyc + 1, 1, 2'd0, "auto_hold");
        step(1);
        sw.tick   = 1'b0;
        sw.cur_ts = 3'd0;
        sw.cur_ss = 4'd0;
        step(4);

        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s never compared due=%0d expected=%0d", e.name, e.at, e.val);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
